// File: rtl/if_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_if
//   Bundles the fetch front end's external handshakes: the redirect input, the
//   instruction-memory request/response channel and the IF/ID valid/ready
//   channel.
//
//   modport master : used by if_fetch_queue (drives imem request and IF/ID)
//   modport slave  : used by the environment (memory, decode, branch unit)
//
//   redirect_valid / redirect_pc      flush request and new fetch address
//   imem_req_valid / _ready / _addr   fetch request channel
//   imem_resp_valid / imem_resp_data  in-order instruction responses
//   id_valid / id_ready / id_instr / id_pc   head of queue towards decode
// -----------------------------------------------------------------------------
interface if_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready,
           imem_resp_valid, imem_resp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready,
           imem_resp_valid, imem_resp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch front end. Holds the fetch PC, issues in-order requests
//   to instruction memory, queues {pc, instr} pairs and presents them to decode
//   over valid/ready. A redirect flushes the queue, reloads the fetch PC and
//   arranges for all responses still in flight to be discarded.
//
//   Ports:
//     clk     in   rising-edge clock
//     reset   in   asynchronous active-low reset
//     fq      if   if_fetch_queue_if.master (redirect, imem req/resp, IF/ID)
//     perf_stall_cnt / perf_drop_cnt  out 32 (only with FETCH_PERF_EN)
//
//   Optional feature macro: FETCH_PERF_EN
//     defined   : adds saturating counters of decode-starved cycles
//                 (id_ready=1, id_valid=0) and of discarded responses.
//     undefined : the counters and their ports are absent.
//
//   Parameters: DEPTH (power of 2, >=2) queue entries and max outstanding
//   requests; RESET_PC fetch PC loaded on reset.
// -----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_queue_if.master  fq
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Queue storage and control state
  logic [31:0]     pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   head_q, head_d;   // oldest allocated entry
  logic [AW-1:0]   tail_q, tail_d;   // next entry to allocate
  logic [AW-1:0]   fill_q, fill_d;   // oldest allocated-but-unfilled entry
  logic [CW-1:0]   occ_q, occ_d;     // allocated entries, filled or not
  logic [CW-1:0]   pend_q, pend_d;   // allocated entries awaiting data
  logic [CW-1:0]   drop_q, drop_d;   // in-flight responses to discard

  logic            head_filled;
  logic            room;
  logic            req_valid;
  logic            req_fire;
  logic            pop;
  logic            resp_fill;
  logic [CW-1:0]   flush_drop;

  logic [DEPTH-1:0] alloc_vec;
  logic [DEPTH-1:0] fill_vec;
  logic [DEPTH-1:0] pop_vec;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign head_filled = filled_q[head_q];

  // Drop credits count against capacity so that every response that can still
  // arrive has a tracked slot or credit to land in.
  assign room      = ({1'b0, occ_q} + {1'b0, drop_q}) < (CW+1)'(DEPTH);
  // Gated by reset so the request stays low while reset is held.
  assign req_valid = reset & ~fq.redirect_valid & room;
  assign req_fire  = req_valid & fq.imem_req_ready;
  assign pop       = head_filled & fq.id_ready & ~fq.redirect_valid;
  assign resp_fill = fq.imem_resp_valid & (drop_q == '0) & ~fq.redirect_valid;

  assign fq.imem_req_valid = req_valid;
  assign fq.imem_req_addr  = fetch_pc_q;
  assign fq.id_valid       = head_filled;
  assign fq.id_pc          = head_filled ? pc_q[head_q]    : 32'h0;
  assign fq.id_instr       = head_filled ? instr_q[head_q] : 32'h0;

  // Per-entry write enables
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry_en
      assign alloc_vec[gi] = req_fire  && (tail_q == AW'(gi));
      assign fill_vec[gi]  = resp_fill && (fill_q == AW'(gi));
      assign pop_vec[gi]   = pop       && (head_q == AW'(gi));
    end
  endgenerate

  // Responses outstanding at the redirect become drop credits; a response
  // arriving in the redirect cycle itself is consumed from that total.
  always_comb begin
    flush_drop = pend_q + drop_q;
    if (fq.imem_resp_valid && flush_drop != '0) begin
      flush_drop = flush_drop - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    occ_d      = occ_q;
    pend_d     = pend_q;
    drop_d     = drop_q;

    if (fq.redirect_valid) begin
      fetch_pc_d = {fq.redirect_pc[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      occ_d      = '0;
      pend_d     = '0;
      drop_d     = flush_drop;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tail_d     = tail_q + AW'(1);
      end
      if (resp_fill) begin
        fill_d = fill_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      occ_d  = occ_q  + CW'(req_fire) - CW'(pop);
      pend_d = pend_q + CW'(req_fire) - CW'(resp_fill);
      if (fq.imem_resp_valid && drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      occ_q      <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
    end
  end

  // Filled flags: a popped slot is cleared so a later empty queue never sees a
  // stale flag at the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filled_q <= '0;
    end else if (fq.redirect_valid) begin
      filled_q <= '0;
    end else begin
      filled_q <= (filled_q & ~alloc_vec & ~pop_vec) | fill_vec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= 32'h0;
        instr_q[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_vec[i]) pc_q[i]    <= fetch_pc_q;
        if (fill_vec[i])  instr_q[i] <= fq.imem_resp_data;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q;
  logic [31:0] drop_cnt_q;
  logic        discard;

  assign discard = fq.imem_resp_valid & ((drop_q != '0) | fq.redirect_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'h0;
      drop_cnt_q  <= 32'h0;
    end else begin
      if (fq.id_ready && !head_filled && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (discard && drop_cnt_q != 32'hFFFF_FFFF) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
//   Self-checking bench for if_fetch_queue. A memory model answers requests in
//   order one cycle after acceptance (or holds them while stalled); a
//   scoreboard records the expected {pc, instr} of every accepted request and
//   compares it against each IF/ID handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_fetch_queue_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .fq             (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];      // expected pcs in decode order
  logic [31:0] mq[$];         // addresses accepted by memory, awaiting response
  logic [31:0] fire_addr[$];  // addresses of accepted requests
  logic [31:0] model_pc;
  bit          resp_en;
  int          pops;
  int          fires;
  logic [31:0] first_pop_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic clear_stats();
    pops = 0;
    fires = 0;
    first_pop_pc = 32'hDEAD_BEEF;
    fire_addr.delete();
  endtask

  // One clock cycle: sample handshakes before the edge, model memory after it.
  task automatic tick();
    bit          fire;
    bit          popped;
    logic [31:0] fa;
    logic [31:0] e;
    #1;
    fire   = bus.imem_req_valid && bus.imem_req_ready;
    popped = bus.id_valid && bus.id_ready && !bus.redirect_valid;
    fa     = bus.imem_req_addr;
    if (bus.redirect_valid) begin
      checks++;
      if (bus.imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_during_redirect: got %b expected 0", bus.imem_req_valid);
      end
    end
    if (fire) begin
      checks++;
      if (fa !== model_pc) begin
        errors++;
        $display("FAIL req_addr: got %h expected %h", fa, model_pc);
      end
      exp_q.push_back(model_pc);
      fire_addr.push_back(fa);
      fires++;
      model_pc = model_pc + 32'd4;
    end
    if (popped) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL id_unexpected: got pc %h expected no valid", bus.id_pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.id_pc !== e || bus.id_instr !== instr_of(e)) begin
          errors++;
          $display("FAIL id_data: got pc %h instr %h expected pc %h instr %h",
                   bus.id_pc, bus.id_instr, e, instr_of(e));
        end
      end
      if (pops == 0) first_pop_pc = bus.id_pc;
      pops++;
      $display("pop pc=%h instr=%h", bus.id_pc, bus.id_instr);
    end
    if (bus.redirect_valid) begin
      exp_q.delete();
      model_pc = {bus.redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    if (fire) mq.push_back(fa);
    if (resp_en && mq.size() > 0) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = instr_of(mq.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.id_ready        = 1'b0;
    exp_q.delete();
    mq.delete();
    model_pc = RESET_PC;
    resp_en  = 1'b1;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid); end
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b expected 0", bus.id_valid); end
    checks++;
    if (bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0) begin
      errors++; $display("FAIL rst_id_data: got pc %h instr %h expected 0 0", bus.id_pc, bus.id_instr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin
      errors++; $display("FAIL rst_perf: got %h %h expected 0 0", perf_stall_cnt, perf_drop_cnt);
    end
`endif
    reset = 1'b1;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
      errors++; $display("FAIL rst_release_req: got %b %h expected 1 %h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    do_reset();
    bus.id_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (pops !== 10) begin errors++; $display("FAIL stream_pops: got %0d expected 10", pops); end
    checks++;
    if (first_pop_pc !== 32'h0) begin errors++; $display("FAIL stream_first_pc: got %h expected 0", first_pop_pc); end
  endtask

  task automatic test_full();
    do_reset();
    repeat (10) tick();
    checks++;
    if (fires !== DEPTH) begin errors++; $display("FAIL full_fires: got %0d expected %0d", fires, DEPTH); end
    bus.id_ready = 1'b1;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.id_valid !== 1'b1) begin
      errors++; $display("FAIL full_pop_cycle: got req %b idv %b expected 0 1", bus.imem_req_valid, bus.id_valid);
    end
    tick();
    checks++;
    if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL full_reenable: got %b expected 1", bus.imem_req_valid); end
    repeat (8) tick();
    checks++;
    if (pops < 4 || first_pop_pc !== 32'h0) begin
      errors++; $display("FAIL full_drain: got pops %0d first %h expected >=4 0", pops, first_pop_pc);
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    bus.id_ready = 1'b1;
    resp_en = 1'b0;
    repeat (2) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    resp_en = 1'b1;
    clear_stats();
    repeat (10) tick();
    checks++;
    if (pops == 0 || first_pop_pc !== 32'h100) begin
      errors++; $display("FAIL redir_first_pc: got pops %0d pc %h expected >0 100", pops, first_pop_pc);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_drop_cnt !== 32'd2) begin errors++; $display("FAIL perf_drop: got %0d expected 2", perf_drop_cnt); end
`endif
  endtask

  task automatic test_redirect_collide();
    do_reset();
    bus.id_ready = 1'b1;
    repeat (2) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    checks++;
    if (bus.id_valid !== 1'b1 || bus.imem_resp_valid !== 1'b1) begin
      errors++; $display("FAIL collide_setup: got idv %b resp %b expected 1 1", bus.id_valid, bus.imem_resp_valid);
    end
    clear_stats();
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || pops !== 0) begin
      errors++; $display("FAIL collide_flush: got idv %b pops %0d expected 0 0", bus.id_valid, pops);
    end
    repeat (6) tick();
    checks++;
    if (pops == 0 || first_pop_pc !== 32'h200) begin
      errors++; $display("FAIL collide_first_pc: got pops %0d pc %h expected >0 200", pops, first_pop_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    tick();
    bus.redirect_valid = 1'b0;
    clear_stats();
    repeat (5) tick();
    checks++;
    if (fire_addr.size() < 2) begin
      errors++; $display("FAIL wrap_fires: got %0d expected >=2", fire_addr.size());
    end else if (fire_addr[0] !== 32'hFFFF_FFFC || fire_addr[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: got %h %h expected fffffffc 00000000", fire_addr[0], fire_addr[1]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 ||
        bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0) begin
      errors++; $display("FAIL async_reset: got idv %b req %b pc %h instr %h expected 0 0 0 0",
                         bus.id_valid, bus.imem_req_valid, bus.id_pc, bus.id_instr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin
      errors++; $display("FAIL async_perf: got %h %h expected 0 0", perf_stall_cnt, perf_drop_cnt);
    end
`endif
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    exp_q.delete();
    mq.delete();
    model_pc = RESET_PC;
    clear_stats();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.id_ready = 1'b1;
    repeat (8) tick();
    checks++;
    if (pops == 0 || first_pop_pc !== RESET_PC) begin
      errors++; $display("FAIL async_restart: got pops %0d pc %h expected >0 %h", pops, first_pop_pc, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
